// File: rtl/ad_sample_sched_if.sv
// ad_sample_sched_if - signal bundle between the ADC capture stage, the
// measurement scheduler and the MPPT consumer.
//   ad_ch1/ad_ch2 : registered 12-bit ADC codes (voltage / current)
//   req           : measurement request
//   pair_valid/pair_ready : result handshake
//   v_avg/i_avg   : averaged channel results
//   busy, req_drop, ovr   : status
// master = scheduler side, slave = producer/consumer side.
interface ad_sample_sched_if;
  logic [11:0] ad_ch1;
  logic [11:0] ad_ch2;
  logic        req;
  logic        pair_ready;
  logic        pair_valid;
  logic [11:0] v_avg;
  logic [11:0] i_avg;
  logic        busy;
  logic        req_drop;
  logic [1:0]  ovr;

  modport master (
    input  ad_ch1, ad_ch2, req, pair_ready,
    output pair_valid, v_avg, i_avg, busy, req_drop, ovr
  );

  modport slave (
    output ad_ch1, ad_ch2, req, pair_ready,
    input  pair_valid, v_avg, i_avg, busy, req_drop, ovr
  );
endinterface

// File: rtl/ad_sample_sched.sv
// ad_sample_sched - measurement scheduler for the dual AD9226 capture path.
// On req it runs a sample strobe every DIV clocks, discards SETTLE strobes,
// then averages 2^AVG_LOG2 simultaneous samples of both channels and holds
// the averaged pair on a valid/ready handshake.
// Ports:
//   clk50m : clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : ad_sample_sched_if.master (inputs ad_ch1, ad_ch2, req,
//            pair_ready; outputs pair_valid, v_avg, i_avg, busy,
//            req_drop, ovr)
// Optional feature: define AD_OVERRANGE_EN to build the overrange flags
// (ovr); otherwise ovr is tied to 2'b00.
module ad_sample_sched #(
  parameter int DIV      = 50,
  parameter int AVG_LOG2 = 4,
  parameter int SETTLE   = 8
) (
  input logic clk50m,
  input logic reset,
  ad_sample_sched_if.master bus
);

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int DW    = $clog2(DIV);
  localparam logic [DW-1:0] DIV_M1 = DW'(DIV - 1);
  localparam logic [8:0] SET_M1 = 9'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [8:0] AVG_M1 = 9'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACCUM, S_HOLD} state_t;

  state_t            state, state_nx;
  logic [DW-1:0]     div;
  logic              strobe;
  logic [8:0]        cnt;     // strobes seen in the current phase
  logic [ACC_W-1:0]  acc1, acc2, sum1, sum2;
  logic [11:0]       v_q, i_q;
  logic              drop_q;
  logic              last;

  assign strobe = (div == DIV_M1);
  assign sum1   = acc1 + ACC_W'(bus.ad_ch1);
  assign sum2   = acc2 + ACC_W'(bus.ad_ch2);
  // final sample: its addition and the result latch share this edge
  assign last   = (state == S_ACCUM) && strobe && (cnt == AVG_M1);

  always_ff @(posedge clk50m or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (bus.req) state_nx = (SETTLE == 0) ? S_ACCUM : S_SETTLE;
      S_SETTLE: if (strobe && cnt == SET_M1) state_nx = S_ACCUM;
      S_ACCUM:  if (last) state_nx = S_HOLD;
      S_HOLD:   if (bus.pair_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk50m or posedge reset) begin
    if (reset) begin
      div    <= '0;
      cnt    <= '0;
      acc1   <= '0;
      acc2   <= '0;
      v_q    <= '0;
      i_q    <= '0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= bus.req && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          // divider, counter and accumulators sit cleared while idle, so
          // the accepting edge starts a fresh measurement at div = 0
          div  <= '0;
          cnt  <= '0;
          acc1 <= '0;
          acc2 <= '0;
        end
        S_SETTLE: begin
          div <= strobe ? '0 : div + 1'b1;
          if (strobe) cnt <= (cnt == SET_M1) ? '0 : cnt + 1'b1;
        end
        S_ACCUM: begin
          div <= strobe ? '0 : div + 1'b1;
          if (strobe) begin
            acc1 <= sum1;
            acc2 <= sum2;
            cnt  <= cnt + 1'b1;
            if (last) begin
              v_q <= sum1[ACC_W-1:AVG_LOG2];
              i_q <= sum2[ACC_W-1:AVG_LOG2];
            end
          end
        end
        default: div <= '0;
      endcase
    end
  end

  assign bus.pair_valid = (state == S_HOLD);
  assign bus.busy       = (state != S_IDLE);
  assign bus.v_avg      = v_q;
  assign bus.i_avg      = i_q;
  assign bus.req_drop   = drop_q;

`ifdef AD_OVERRANGE_EN
  logic [1:0] smp_ovr, ovr_st, ovr_q;

  assign smp_ovr = {(bus.ad_ch2 == 12'h000) || (bus.ad_ch2 == 12'hFFF),
                    (bus.ad_ch1 == 12'h000) || (bus.ad_ch1 == 12'hFFF)};

  // sticky per measurement; only ACCUM samples are checked, and the
  // visible flags move only with the result latch
  always_ff @(posedge clk50m or posedge reset) begin
    if (reset) begin
      ovr_st <= 2'b00;
      ovr_q  <= 2'b00;
    end else begin
      if (state == S_IDLE)
        ovr_st <= 2'b00;
      else if (state == S_ACCUM && strobe)
        ovr_st <= ovr_st | smp_ovr;
      if (last) ovr_q <= ovr_st | smp_ovr;
    end
  end

  assign bus.ovr = ovr_q;
`else
  assign bus.ovr = 2'b00;
`endif

endmodule

// File: tb/tb_ad_sample_sched.sv
// tb_ad_sample_sched - directed bench for ad_sample_sched.
// Instance a: DIV=4, AVG_LOG2=2, SETTLE=1 (5 strobes, latency 20 cycles).
// Instance b: DIV=2, AVG_LOG2=8, SETTLE=0 (256 strobes, latency 512 cycles).
// Expected results are pushed to per-instance queues at request time and
// popped by monitors when the DUT hands a result over.
module tb_ad_sample_sched;

  localparam int DIV = 4;

`ifdef AD_OVERRANGE_EN
  localparam bit OVR_ON = 1'b1;
`else
  localparam bit OVR_ON = 1'b0;
`endif

  typedef struct packed {
    logic [11:0] v;
    logic [11:0] i;
    logic [1:0]  o;
  } res_t;

  typedef logic [11:0] smp_t [5];

  logic clk50m = 1'b0;
  logic reset  = 1'b1;
  always #10 clk50m = ~clk50m;

  ad_sample_sched_if a();
  ad_sample_sched_if b();

  ad_sample_sched #(.DIV(4), .AVG_LOG2(2), .SETTLE(1)) dut_a (
    .clk50m(clk50m), .reset(reset), .bus(a.master));

  ad_sample_sched #(.DIV(2), .AVG_LOG2(8), .SETTLE(0)) dut_b (
    .clk50m(clk50m), .reset(reset), .bus(b.master));

  int   n_chk  = 0;
  int   n_fail = 0;
  res_t qa[$];
  res_t qb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard monitors: a result is consumed at the edge after this sample
  always @(negedge clk50m) begin
    res_t e;
    if (!reset && a.pair_valid && a.pair_ready) begin
      chk("a_result_expected", 32'(qa.size() != 0), 1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("a_v_avg", 32'(a.v_avg), 32'(e.v));
        chk("a_i_avg", 32'(a.i_avg), 32'(e.i));
        chk("a_ovr",   32'(a.ovr),   32'(e.o));
      end
    end
  end

  always @(negedge clk50m) begin
    res_t e;
    if (!reset && b.pair_valid && b.pair_ready) begin
      chk("b_result_expected", 32'(qb.size() != 0), 1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_v_avg", 32'(b.v_avg), 32'(e.v));
        chk("b_i_avg", 32'(b.i_avg), 32'(e.i));
        chk("b_ovr",   32'(b.ovr),   32'(e.o));
      end
    end
  end

  // one measurement on instance a: sample m is held for the strobe at k+(m+1)*DIV
  task automatic meas_a(input smp_t c1, input smp_t c2, input res_t e, input string nm);
    qa.push_back(e);
    a.ad_ch1 = c1[0];
    a.ad_ch2 = c2[0];
    a.req    = 1'b1;
    @(posedge clk50m); #1;
    a.req = 1'b0;
    chk({nm, "_busy_up"}, 32'(a.busy), 1);
    for (int m = 0; m < 5; m++) begin
      a.ad_ch1 = c1[m];
      a.ad_ch2 = c2[m];
      repeat (DIV - 1) @(posedge clk50m);
      @(negedge clk50m);
      if (m == 4) chk({nm, "_valid_early"}, 32'(a.pair_valid), 0);
      @(posedge clk50m); #1;
    end
    chk({nm, "_valid_at_latency"}, 32'(a.pair_valid), 1);
  endtask

  task automatic consume_a(input int wait_n, input string nm);
    a.pair_ready = 1'b0;
    repeat (wait_n) @(posedge clk50m);
    #1;
    a.pair_ready = 1'b1;
    @(posedge clk50m); #1;
    a.pair_ready = 1'b0;
    chk({nm, "_valid_down"}, 32'(a.pair_valid), 0);
    chk({nm, "_busy_down"},  32'(a.busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    smp_t s1, s2;
    int   drops;
    a.ad_ch1 = '0; a.ad_ch2 = '0; a.req = 1'b0; a.pair_ready = 1'b0;
    b.ad_ch1 = '0; b.ad_ch2 = '0; b.req = 1'b0; b.pair_ready = 1'b0;
    #1;
    chk("rst_pair_valid", 32'(a.pair_valid), 0);
    chk("rst_busy",       32'(a.busy), 0);
    chk("rst_v_avg",      32'(a.v_avg), 0);
    chk("rst_i_avg",      32'(a.i_avg), 0);
    chk("rst_req_drop",   32'(a.req_drop), 0);
    chk("rst_ovr",        32'(a.ovr), 0);
    chk("rst_b_valid",    32'(b.pair_valid), 0);
    repeat (3) @(posedge clk50m);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk50m);
    #1;

    // basic latency and averaging
    s1 = '{12'h800, 12'h800, 12'h800, 12'h800, 12'h800};
    s2 = '{12'h123, 12'h123, 12'h123, 12'h123, 12'h123};
    meas_a(s1, s2, '{v: 12'h800, i: 12'h123, o: 2'b00}, "basic");
    consume_a(0, "basic");

    // truncation: accumulated 1,2,3,5 -> 11>>2 = 2; 10,20,30,40 -> 100>>2 = 25
    s1 = '{12'd7, 12'd1, 12'd2, 12'd3, 12'd5};
    s2 = '{12'd9, 12'd10, 12'd20, 12'd30, 12'd40};
    meas_a(s1, s2, '{v: 12'd2, i: 12'd25, o: 2'b00}, "trunc");
    consume_a(2, "trunc");

    // backpressure with a request dropped during HOLD
    s1 = '{12'h555, 12'h555, 12'h555, 12'h555, 12'h555};
    s2 = '{12'hAAA, 12'hAAA, 12'hAAA, 12'hAAA, 12'hAAA};
    meas_a(s1, s2, '{v: 12'h555, i: 12'hAAA, o: 2'b00}, "bp");
    drops = 0;
    for (int c = 0; c < 20; c++) begin
      a.req = (c == 5);
      @(posedge clk50m); #1;
      a.req = 1'b0;
      if (a.req_drop) drops++;
      chk("bp_valid_hold", 32'(a.pair_valid), 1);
      chk("bp_v_stable",   32'(a.v_avg), 32'h555);
      chk("bp_i_stable",   32'(a.i_avg), 32'hAAA);
    end
    chk("bp_req_drop_pulses", 32'(drops), 1);
    consume_a(0, "bp");
    repeat (3) @(posedge clk50m);
    #1;
    chk("bp_no_restart", 32'(a.busy), 0);
    chk("bp_data_kept",  32'(a.v_avg), 32'h555);

    // req and pair_ready together in HOLD
    s1 = '{12'h111, 12'h111, 12'h111, 12'h111, 12'h111};
    s2 = '{12'h222, 12'h222, 12'h222, 12'h222, 12'h222};
    meas_a(s1, s2, '{v: 12'h111, i: 12'h222, o: 2'b00}, "reqrdy");
    a.req = 1'b1;
    a.pair_ready = 1'b1;
    @(posedge clk50m); #1;
    a.req = 1'b0;
    a.pair_ready = 1'b0;
    chk("reqrdy_valid_down", 32'(a.pair_valid), 0);
    chk("reqrdy_busy_down",  32'(a.busy), 0);
    chk("reqrdy_req_drop",   32'(a.req_drop), 1);
    @(posedge clk50m); #1;
    chk("reqrdy_idle",       32'(a.busy), 0);
    chk("reqrdy_drop_clear", 32'(a.req_drop), 0);

    // reset in the middle of ACCUM, then a full-latency measurement
    a.ad_ch1 = 12'h300;
    a.ad_ch2 = 12'h300;
    a.req = 1'b1;
    @(posedge clk50m); #1;
    a.req = 1'b0;
    repeat (10) @(posedge clk50m);
    #1 reset = 1'b1;
    #1;
    chk("mrst_pair_valid", 32'(a.pair_valid), 0);
    chk("mrst_busy",       32'(a.busy), 0);
    chk("mrst_v_avg",      32'(a.v_avg), 0);
    chk("mrst_i_avg",      32'(a.i_avg), 0);
    chk("mrst_req_drop",   32'(a.req_drop), 0);
    chk("mrst_ovr",        32'(a.ovr), 0);
    repeat (3) @(posedge clk50m);
    #1 reset = 1'b0;
    @(posedge clk50m); #1;
    s1 = '{12'h0AB, 12'h0AB, 12'h0AB, 12'h0AB, 12'h0AB};
    s2 = '{12'h0CD, 12'h0CD, 12'h0CD, 12'h0CD, 12'h0CD};
    meas_a(s1, s2, '{v: 12'h0AB, i: 12'h0CD, o: 2'b00}, "postrst");
    consume_a(1, "postrst");

    // overrange sample in ACCUM: (FFF+1+1+1)>>2 = 0x400
    s1 = '{12'h100, 12'hFFF, 12'd1, 12'd1, 12'd1};
    s2 = '{12'h200, 12'h200, 12'h200, 12'h200, 12'h200};
    meas_a(s1, s2, '{v: 12'h400, i: 12'h200, o: (OVR_ON ? 2'b01 : 2'b00)}, "ovr_acc");
    consume_a(0, "ovr_acc");

    // overrange codes only during SETTLE are not flagged
    s1 = '{12'hFFF, 12'd4, 12'd4, 12'd4, 12'd4};
    s2 = '{12'h000, 12'h200, 12'h200, 12'h200, 12'h200};
    meas_a(s1, s2, '{v: 12'd4, i: 12'h200, o: 2'b00}, "ovr_settle");
    consume_a(0, "ovr_settle");

    // full scale, 256 samples, SETTLE=0: latency 256*2 = 512 cycles
    qb.push_back('{v: 12'hFFF, i: 12'hFFF, o: (OVR_ON ? 2'b11 : 2'b00)});
    b.ad_ch1 = 12'hFFF;
    b.ad_ch2 = 12'hFFF;
    b.req = 1'b1;
    @(posedge clk50m); #1;
    b.req = 1'b0;
    chk("fs_busy_up", 32'(b.busy), 1);
    repeat (511) @(posedge clk50m);
    @(negedge clk50m);
    chk("fs_valid_early", 32'(b.pair_valid), 0);
    @(posedge clk50m); #1;
    chk("fs_valid_at_latency", 32'(b.pair_valid), 1);
    b.pair_ready = 1'b1;
    @(posedge clk50m); #1;
    b.pair_ready = 1'b0;
    chk("fs_valid_down", 32'(b.pair_valid), 0);
    chk("fs_busy_down",  32'(b.busy), 0);

    repeat (2) @(posedge clk50m);
    #1;
    chk("a_queue_drained", 32'(qa.size()), 0);
    chk("b_queue_drained", 32'(qb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
